// File: rtl/ms_bcd_counter_if.sv
// Command and result bundle between the reaction-timer control logic and the
// millisecond BCD counter; the counter sits on the slave side.
interface ms_bcd_counter_if #(
    parameter int DIGITS = 4
);
    logic                  tick_in;
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  running;
    logic                  overflow;
    logic                  done;

    modport master (
        output tick_in, start, stop, clear,
        input  bcd_out, running, overflow, done
    );

    modport slave (
        input  tick_in, start, stop, clear,
        output bcd_out, running, overflow, done
    );
endinterface

// File: rtl/ms_bcd_counter.sv
// Millisecond reaction-time counter: counts 1 kHz ticks in packed BCD between
// start and stop, saturates at all-nines and flags overflow.
module ms_bcd_counter #(
    parameter int DIGITS = 4
) (
    input logic              clk,
    input logic              rst_n,
    ms_bcd_counter_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    state_e         state_q;
    logic [W-1:0]   bcd_q;
    logic [W-1:0]   bcd_d;
    logic           full_d;
    logic           running_q;
    logic           overflow_q;
    logic           done_q;

    // Ripple increment across every digit in a single cycle.
    function automatic logic [W-1:0] bcd_incr(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic is_full(input logic [W-1:0] v);
        logic f;
        f = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) f = 1'b0;
        end
        return f;
    endfunction

    always_comb begin
        bcd_d  = bcd_incr(bcd_q);
        full_d = is_full(bcd_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A tick coinciding with start is deliberately not counted.
                    if (!bus.clear && bus.start) begin
                        state_q    <= RUN;
                        running_q  <= 1'b1;
                        bcd_q      <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.clear) begin
                        state_q    <= IDLE;
                        running_q  <= 1'b0;
                        bcd_q      <= '0;
                        overflow_q <= 1'b0;
                    end else if (bus.stop) begin
                        state_q   <= HOLD;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (bus.tick_in) begin
                        if (full_d) overflow_q <= 1'b1;
                        else        bcd_q      <= bcd_d;
                    end
                end
                HOLD: begin
                    if (bus.clear) begin
                        state_q    <= IDLE;
                        bcd_q      <= '0;
                        overflow_q <= 1'b0;
                    end else if (bus.start) begin
                        state_q    <= RUN;
                        running_q  <= 1'b1;
                        bcd_q      <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bcd_out  = bcd_q;
    assign bus.running  = running_q;
    assign bus.overflow = overflow_q;
    assign bus.done     = done_q;
endmodule
